decoder_stage_controller: RTL and testbench

Global stage sequencer for the single-FPGA union-find decoder array. It drives `global_stage` to every processing unit and accepts a syndrome round through a valid/ready handshake. It steps the array through grow/merge iterations until no cluster is odd, runs peeling until the array reports idle, then presents a result-valid handshake. It is the sole source of `global_stage` and the sole consumer of the array's `busy` and `odd` vectors.

---
 rtl/decoder_stage_controller.sv | 176 +++++++++++++++++
 tb/tb_decoder_stage_controller.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decoder_stage_controller.sv
// Global stage sequencer for the union-find decoder array.
// Optional iteration limit: define STAGE_CTRL_ITER_LIMIT_EN.
module decoder_stage_controller #(
    parameter int PU_COUNT      = 64,
    parameter int STAGE_WIDTH   = 3,
    parameter int SETTLE_CYCLES = 3,
    parameter int ITER_WIDTH    = 8,
    parameter int CYCLE_WIDTH   = 16,
    parameter int MAX_ITER      = 200
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   meas_valid,
    output logic                   meas_ready,
    input  logic [PU_COUNT-1:0]    busy,
    input  logic [PU_COUNT-1:0]    odd,
    output logic [STAGE_WIDTH-1:0] global_stage,
    output logic                   result_valid,
    input  logic                   result_ready,
    output logic [ITER_WIDTH-1:0]  iteration_count,
    output logic [CYCLE_WIDTH-1:0] cycle_count,
    output logic                   decode_error
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_PREP     = 3'd1,
        S_LOAD     = 3'd2,
        S_GROW     = 3'd3,
        S_MERGE    = 3'd4,
        S_PEEL     = 3'd5,
        S_RESULT   = 3'd6,
        S_ERASURE  = 3'd7
    } stage_e;

    localparam int CNT_W = $clog2(SETTLE_CYCLES + 1) + 1;

    stage_e r_state;
    stage_e w_next;

    logic [CNT_W-1:0]       r_stage_cnt;
    logic [ITER_WIDTH-1:0]  r_iter;
    logic [CYCLE_WIDTH-1:0] r_cycles;

    logic w_busy_any;
    logic w_odd_any;
    logic w_settled;
    logic w_at_limit;
    logic w_accept;
    logic w_set_err;
    logic w_ready;
    logic w_rvalid;

    assign w_busy_any = |busy;
    assign w_odd_any  = |odd;
    assign w_settled  = (r_stage_cnt >= CNT_W'(SETTLE_CYCLES));
    assign w_at_limit = (r_iter == ITER_WIDTH'(MAX_ITER));

    assign global_stage    = STAGE_WIDTH'(r_state);
    assign meas_ready      = w_ready;
    assign result_valid    = w_rvalid;
    assign iteration_count = r_iter;
    assign cycle_count     = r_cycles;

    // Stage register; synchronous reset aborts any round in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-stage selection and handshake outputs.
    always_comb begin
        w_next    = r_state;
        w_ready   = 1'b0;
        w_rvalid  = 1'b0;
        w_accept  = 1'b0;
        w_set_err = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                w_ready = 1'b1;
                if (meas_valid) begin
                    w_accept = 1'b1;
                    w_next   = S_PREP;
                end
            end
            S_PREP: w_next = S_LOAD;
            // Zero-syndrome rounds must skip growth entirely.
            S_LOAD: w_next = S_MERGE;
            S_GROW: w_next = S_MERGE;
            S_MERGE: begin
                if (w_settled && !w_busy_any) begin
                    if (w_odd_any) begin
`ifdef STAGE_CTRL_ITER_LIMIT_EN
                        if (w_at_limit) begin
                            w_next    = S_PEEL;
                            w_set_err = 1'b1;
                        end else begin
                            w_next = S_GROW;
                        end
`else
                        w_next = S_GROW;
`endif
                    end else begin
                        w_next = S_PEEL;
                    end
                end
            end
            S_PEEL: begin
                if (w_settled && !w_busy_any) begin
                    w_next = S_RESULT;
                end
            end
            S_RESULT: begin
                w_rvalid = 1'b1;
                if (result_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Settle counter: zero on every stage entry, saturating otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stage_cnt <= '0;
        end else if (w_next != r_state) begin
            r_stage_cnt <= '0;
        end else if (r_stage_cnt != {CNT_W{1'b1}}) begin
            r_stage_cnt <= r_stage_cnt + 1'b1;
        end
    end

    // Grow iterations: counted on GROW entry, saturating.
    always_ff @(posedge clk) begin
        if (reset || w_accept) begin
            r_iter <= '0;
        end else if (w_next == S_GROW && r_state != S_GROW
                     && r_iter != {ITER_WIDTH{1'b1}}) begin
            r_iter <= r_iter + 1'b1;
        end
    end

    // Decode latency: counts every active cycle, frozen in IDLE/RESULT.
    always_ff @(posedge clk) begin
        if (reset || w_accept) begin
            r_cycles <= '0;
        end else if (r_state != S_IDLE && r_state != S_RESULT
                     && r_cycles != {CYCLE_WIDTH{1'b1}}) begin
            r_cycles <= r_cycles + 1'b1;
        end
    end

`ifdef STAGE_CTRL_ITER_LIMIT_EN
    logic r_err;

    // Limit flag: sticky until the next accepted round.
    always_ff @(posedge clk) begin
        if (reset || w_accept) begin
            r_err <= 1'b0;
        end else if (w_set_err) begin
            r_err <= 1'b1;
        end
    end

    assign decode_error = r_err;
`else
    logic w_unused_limit;
    assign w_unused_limit = w_at_limit ^ w_set_err;
    assign decode_error   = 1'b0;
`endif

endmodule

// File: tb/tb_decoder_stage_controller.sv
// Randomized bench for decoder_stage_controller.
// Expected stage traces are planned per round from the stage rules.
module tb_decoder_stage_controller;

    localparam int PU  = 64;
    localparam int SET = 3;
`ifdef STAGE_CTRL_ITER_LIMIT_EN
    localparam int TB_MAX_ITER = 3;
    localparam bit LIMIT_ON    = 1'b1;
`else
    localparam int TB_MAX_ITER = 200;
    localparam bit LIMIT_ON    = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          meas_valid;
    logic          meas_ready;
    logic [PU-1:0] busy;
    logic [PU-1:0] odd;
    logic [2:0]    global_stage;
    logic          result_valid;
    logic          result_ready;
    logic [7:0]    iteration_count;
    logic [15:0]   cycle_count;
    logic          decode_error;

    int checks = 0;
    int errors = 0;

    int            exp_q[$];
    logic [PU-1:0] bq[$];
    logic [PU-1:0] oq[$];

    decoder_stage_controller #(
        .PU_COUNT(PU),
        .MAX_ITER(TB_MAX_ITER)
    ) dut (
        .clk(clk),
        .reset(reset),
        .meas_valid(meas_valid),
        .meas_ready(meas_ready),
        .busy(busy),
        .odd(odd),
        .global_stage(global_stage),
        .result_valid(result_valid),
        .result_ready(result_ready),
        .iteration_count(iteration_count),
        .cycle_count(cycle_count),
        .decode_error(decode_error)
    );

    always #5 clk = ~clk;

    function automatic logic [PU-1:0] one_hot();
        logic [PU-1:0] v;
        v = 64'd1 << $urandom_range(PU - 1, 0);
        return v;
    endfunction

    // A settling stage ends on the first idle cycle at or after SET.
    function automatic int dur(input int b, input int g);
        for (int k = SET; k < 64; k++)
            if (!(k < b || k == g)) return k + 1;
        return 64;
    endfunction

    task automatic push1(input int st, input bit oddv);
        exp_q.push_back(st);
        bq.push_back('0);
        oq.push_back(oddv ? one_hot() : '0);
    endtask

    task automatic plan_stage(input int st, input int b, input int g,
                              input bit oddv);
        int d;
        d = dur(b, g);
        for (int k = 0; k < d; k++) begin
            exp_q.push_back(st);
            bq.push_back((k < b || k == g) ? one_hot() : '0);
            oq.push_back(oddv ? one_hot() : '0);
        end
    endtask

    task automatic pick(input bit quiet, output int b, output int g);
        if (quiet) begin
            b = 0;
            g = -1;
        end else begin
            b = $urandom_range(6, 0);
            g = ($urandom_range(1, 0) == 1) ? int'($urandom_range(SET + 4, SET)) : -1;
        end
    endtask

    task automatic build_plan(input int ngrow, input bit odd_last,
                              input bit quiet, input int db, input int dg);
        int b, g;
        exp_q.delete();
        bq.delete();
        oq.delete();
        push1(1, 1'b0);
        push1(2, 1'b0);
        for (int m = 0; m <= ngrow; m++) begin
            if (m == 0 && (db > 0 || dg >= 0)) begin
                b = db;
                g = dg;
            end else begin
                pick(quiet, b, g);
            end
            plan_stage(4, b, g, (m < ngrow) || odd_last);
            if (m < ngrow) push1(3, 1'b1);
        end
        pick(quiet, b, g);
        plan_stage(5, b, g, 1'b0);
    endtask

    task automatic run_round(input int ngrow, input bit odd_last,
                             input bit quiet, input int db, input int dg,
                             input int abort_merge, input int hold,
                             input bit exp_err);
        int abort_t;
        int merges;
        int grows;
        int t_len;
        build_plan(ngrow, odd_last, quiet, db, dg);
        t_len   = exp_q.size();
        abort_t = -1;
        merges  = 0;
        for (int t = 1; t < t_len; t++) begin
            if (exp_q[t] == 4 && exp_q[t-1] != 4) begin
                if (merges == abort_merge) abort_t = t + 1;
                merges++;
            end
        end
        @(negedge clk);
        meas_valid   = 1'b1;
        result_ready = 1'b0;
        busy         = '0;
        odd          = '0;
        checks++;
        if (meas_ready !== 1'b1 || global_stage !== 3'd0) begin
            errors++;
            $display("FAIL idle_ready stage=%0d ready=%0b want 0/1",
                     global_stage, meas_ready);
        end
        @(posedge clk);
        #1;
        grows = 0;
        for (int t = 0; t < t_len; t++) begin
            busy         = bq[t];
            odd          = oq[t];
            meas_valid   = 1'($urandom_range(1, 0));
            result_ready = 1'($urandom_range(1, 0));
            if (exp_q[t] == 3) grows++;
            if (t == abort_t) reset = 1'b1;
            @(negedge clk);
            checks++;
            if (global_stage !== 3'(exp_q[t])) begin
                errors++;
                $display("FAIL stage t=%0d got %0d want %0d",
                         t, global_stage, exp_q[t]);
            end
            checks++;
            if (meas_ready !== 1'b0 || result_valid !== 1'b0) begin
                errors++;
                $display("FAIL busy_hs t=%0d ready=%0b rvalid=%0b want 0/0",
                         t, meas_ready, result_valid);
            end
            checks++;
            if (cycle_count !== 16'(t) || iteration_count !== 8'(grows)) begin
                errors++;
                $display("FAIL cnt_mid t=%0d cyc=%0d it=%0d want %0d/%0d",
                         t, cycle_count, iteration_count, t, grows);
            end
            @(posedge clk);
            #1;
            if (t == abort_t) begin
                reset      = 1'b0;
                meas_valid = 1'b0;
                busy       = '0;
                odd        = '0;
                @(negedge clk);
                checks++;
                if (global_stage !== 3'd0 || meas_ready !== 1'b1
                    || result_valid !== 1'b0 || iteration_count !== 8'd0
                    || cycle_count !== 16'd0 || decode_error !== 1'b0) begin
                    errors++;
                    $display("FAIL abort st=%0d rdy=%0b rv=%0b it=%0d cy=%0d err=%0b want 0/1/0/0/0/0",
                             global_stage, meas_ready, result_valid,
                             iteration_count, cycle_count, decode_error);
                end
                for (int k = 0; k < 15; k++) begin
                    @(negedge clk);
                    checks++;
                    if (result_valid !== 1'b0 || global_stage !== 3'd0) begin
                        errors++;
                        $display("FAIL abort_quiet k=%0d rv=%0b st=%0d want 0/0",
                                 k, result_valid, global_stage);
                    end
                end
                return;
            end
        end
        busy         = '0;
        odd          = '0;
        result_ready = 1'b0;
        for (int h = 0; h <= hold; h++) begin
            meas_valid = 1'b1;
            @(negedge clk);
            checks++;
            if (global_stage !== 3'd6 || result_valid !== 1'b1
                || meas_ready !== 1'b0) begin
                errors++;
                $display("FAIL result_hold h=%0d st=%0d rv=%0b rdy=%0b want 6/1/0",
                         h, global_stage, result_valid, meas_ready);
            end
            checks++;
            if (iteration_count !== 8'(ngrow) || cycle_count !== 16'(t_len)
                || decode_error !== exp_err) begin
                errors++;
                $display("FAIL result_cnt it=%0d cy=%0d err=%0b want %0d/%0d/%0b",
                         iteration_count, cycle_count, decode_error,
                         ngrow, t_len, exp_err);
            end
            if (h < hold) begin
                @(posedge clk);
                #1;
            end
        end
        meas_valid   = 1'b0;
        result_ready = 1'b1;
        @(posedge clk);
        #1;
        result_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (global_stage !== 3'd0 || meas_ready !== 1'b1
            || result_valid !== 1'b0) begin
            errors++;
            $display("FAIL to_idle st=%0d rdy=%0b rv=%0b want 0/1/0",
                     global_stage, meas_ready, result_valid);
        end
        checks++;
        if (iteration_count !== 8'(ngrow) || cycle_count !== 16'(t_len)
            || decode_error !== exp_err) begin
            errors++;
            $display("FAIL idle_hold it=%0d cy=%0d err=%0b want %0d/%0d/%0b",
                     iteration_count, cycle_count, decode_error,
                     ngrow, t_len, exp_err);
        end
    endtask

    task automatic test_reset();
        reset        = 1'b1;
        meas_valid   = 1'b0;
        result_ready = 1'b0;
        busy         = '0;
        odd          = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (global_stage !== 3'd0 || meas_ready !== 1'b1
            || result_valid !== 1'b0 || iteration_count !== 8'd0
            || cycle_count !== 16'd0 || decode_error !== 1'b0) begin
            errors++;
            $display("FAIL reset st=%0d rdy=%0b rv=%0b it=%0d cy=%0d err=%0b want 0/1/0/0/0/0",
                     global_stage, meas_ready, result_valid,
                     iteration_count, cycle_count, decode_error);
        end
    endtask

    task automatic test_zero_syndrome();
        run_round(0, 1'b0, 1'b1, 0, -1, -1, 0, 1'b0);
        checks++;
        if (cycle_count !== 16'd10) begin
            errors++;
            $display("FAIL zero_latency got %0d want 10", cycle_count);
        end
    endtask

    task automatic test_grow_two();
        run_round(2, 1'b0, 1'b1, 0, -1, -1, 0, 1'b0);
    endtask

    task automatic test_busy_stretch();
        run_round(0, 1'b0, 1'b1, 8, -1, -1, 0, 1'b0);
        run_round(1, 1'b0, 1'b1, 0, SET, -1, 0, 1'b0);
    endtask

    task automatic test_result_hold();
        run_round(1, 1'b0, 1'b1, 0, -1, -1, 5, 1'b0);
    endtask

    task automatic test_abort();
        run_round(2, 1'b0, 1'b0, 0, -1, 1, 0, 1'b0);
    endtask

    task automatic test_iter_limit();
        if (LIMIT_ON)
            run_round(TB_MAX_ITER, 1'b1, 1'b1, 0, -1, -1, 1, 1'b1);
        else
            run_round(6, 1'b0, 1'b1, 0, -1, -1, 1, 1'b0);
    endtask

    task automatic test_back_to_back();
        for (int r = 0; r < 10; r++)
            run_round(int'($urandom_range(3, 0)), 1'b0, 1'b0, 0, -1, -1,
                      int'($urandom_range(3, 0)), 1'b0);
    endtask

    initial begin
        test_reset();
        test_zero_syndrome();
        test_grow_two();
        test_busy_stretch();
        test_result_hold();
        test_abort();
        test_iter_limit();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
